sdram_arbiter_rr: RTL and testbench
===================================

Name: sdram_arbiter_rr

Overview:
Parametrised N-master arbiter placed in front of the SDRAM controller. It replaces fixed-priority selection with a selectable round-robin or fixed-priority policy. It adds a bounded bus-lock for back-to-back transactions and routes read data and completion back by master ID. Request fields are flattened vectors so the number of masters scales without port edits.

Parameters:
NUM_MASTERS, 4, number of bus masters (2..7); master k is encoded as ID k+1, and ID 0 means no master.
ADDR_WIDTH, 26, SDRAM word address width.
DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8.
ID_WIDTH, 3, width of sdram_req/sdram_rdvalid; must satisfy 2^ID_WIDTH > NUM_MASTERS.
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
LOCK_LIMIT, 8, maximum consecutive grants a locking master may take before lock is ignored for one arbitration.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
bus_request  in  NUM_MASTERS  per-master request, held until ack
bus_lock  in  NUM_MASTERS  master asks to keep ownership after its ack
bus_addr  in  NUM_MASTERS*ADDR_WIDTH  master k at slice [k*ADDR_WIDTH +: ADDR_WIDTH]
bus_write  in  NUM_MASTERS  1 = write
bus_burst  in  NUM_MASTERS  1 = burst
bus_byte_enable  in  NUM_MASTERS*DATA_WIDTH/8  write byte enables
bus_wdata  in  NUM_MASTERS*DATA_WIDTH  write data
bus_ack  out  NUM_MASTERS  one-hot ack to the owning master
bus_rdata  out  DATA_WIDTH  broadcast read data
bus_rdvalid  out  NUM_MASTERS  one-hot decode of sdram_rdvalid
bus_complete  out  NUM_MASTERS  sdram_complete qualified by owner of the rdvalid ID
sdram_req  out  ID_WIDTH  selected master ID, 0 = idle
sdram_addr  out  ADDR_WIDTH  muxed address
sdram_write  out  1  muxed write
sdram_burst  out  1  muxed burst
sdram_byte_enable  out  DATA_WIDTH/8  muxed byte enables
sdram_wdata  out  DATA_WIDTH  muxed write data
sdram_ack  in  1  controller accepted the request
sdram_rdata  in  DATA_WIDTH  read data
sdram_rdvalid  in  ID_WIDTH  target master ID for sdram_rdata
sdram_complete  in  1  end of transaction
err_bad_id  out  1  sticky flag; set when sdram_rdvalid > NUM_MASTERS

Behaviour:
- Reset (reset_n low, async):
  - owner = 0, last_grant = NUM_MASTERS-1 (so master 0 is searched first), lock_holder = none, lock_count = 0, err_bad_id = 0.
  - All outputs are 0; no X is driven on muxed fields at any time.
- States:
  - IDLE (owner = 0): grant is selected combinationally in the same cycle from bus_request, so sdram_req is valid with zero latency.
  - OWNED (owner = k+1): sdram_req and the muxed fields follow master k until sdram_ack.
- Selection priority in IDLE:
  1. If lock_holder is valid, that master is requesting, and lock_count < LOCK_LIMIT, it wins.
  2. Otherwise, ARB_MODE 0: lowest requesting index wins.
  3. Otherwise, ARB_MODE 1: first requester searching from last_grant+1 upward, wrapping at NUM_MASTERS.
- On sdram_ack:
  - bus_ack[owner-1] = 1 in that cycle only; next-cycle owner = 0; last_grant = owner index.
  - If bus_lock[owner] = 1: lock_holder = owner, lock_count += 1, saturating at LOCK_LIMIT.
  - Else: lock_holder = none, lock_count = 0.
- Grant and ack in the same IDLE cycle are legal: the newly selected master receives the ack, and owner stays 0.
- Lock limit reached: the lock is bypassed for exactly one arbitration, and lock_count clears once a different master is granted.
- Lock holder not requesting in IDLE: the lock is released immediately and normal policy applies.
- Requests with no owner: sdram_req = 0, muxed fields = 0, and sdram_ack is ignored.
- Return path (purely combinational):
  - bus_rdvalid[k] = (sdram_rdvalid == k+1).
  - bus_rdata = sdram_rdata when any rdvalid is set, else 0.
  - bus_complete[k] = sdram_complete & bus_rdvalid[k].
  - An out-of-range ID drives no bus_rdvalid and sets err_bad_id, which clears only on reset.
- Master dropping its request while OWNED is a protocol violation: ownership is held until ack.

Decomposition:
- Package sdram_arb_pkg:
  - arb_mode_t enum {ARB_FIXED, ARB_RR}
  - ID_NONE constant
  - function id_to_index
- Sub-module rr_priority_picker:
  - Parameter N.
  - Inputs req[N], ptr, mode.
  - Outputs grant_valid, grant_index.
  - Implemented as a double-width masked priority encoder.

Test Plan:
- Reset mid-ownership: master 2 owned, reset_n pulsed low -> sdram_req = 0, all acks 0, next request from master 0 granted ID 1.
- Round-robin fairness, all four requesting continuously, ack every 2 cycles -> sdram_req sequence 1,2,3,4,1,2; each ack pulses only on the owner's bit.
- Fixed priority (ARB_MODE = 0), masters 1 and 3 requesting -> master 1 granted every arbitration; master 3 granted only once master 1 deasserts.
- Lock: master 2 holds bus_lock with all requesting, LOCK_LIMIT = 3 -> IDs 3,3,3, then 4 (lock bypassed), then 3.
- Same-cycle grant and ack: idle, bus_request = 4'b1000 with sdram_ack = 1 -> sdram_req = 4 and bus_ack = 4'b1000 in that cycle; owner 0 next cycle.
- Return routing, sdram_rdvalid = 2, complete = 1, rdata = 32'hDEADBEEF -> bus_rdvalid = 4'b0010, bus_complete = 4'b0010, bus_rdata = DEADBEEF; sdram_rdvalid = 6 -> err_bad_id = 1 and stays 1.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and helpers for the SDRAM arbiter.
// Master k travels on the SDRAM side as ID k+1; ID 0 is "no master".
package sdram_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  localparam int ID_NONE = 0;

  function automatic int id_to_index(input int id);
    return id - 1;
  endfunction

endpackage

// File: rtl/sdram_arbiter_rr_if.sv
// sdram_arbiter_rr_if: master-side bus and SDRAM-controller side
// of the arbiter, flattened per master so N scales freely.
interface sdram_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 3
);
  localparam int BW = DATA_WIDTH / 8;

  logic [NUM_MASTERS-1:0]            bus_request;
  logic [NUM_MASTERS-1:0]            bus_lock;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] bus_addr;
  logic [NUM_MASTERS-1:0]            bus_write;
  logic [NUM_MASTERS-1:0]            bus_burst;
  logic [NUM_MASTERS*BW-1:0]         bus_byte_enable;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] bus_wdata;
  logic [NUM_MASTERS-1:0]            bus_ack;
  logic [DATA_WIDTH-1:0]             bus_rdata;
  logic [NUM_MASTERS-1:0]            bus_rdvalid;
  logic [NUM_MASTERS-1:0]            bus_complete;

  logic [ID_WIDTH-1:0]               sdram_req;
  logic [ADDR_WIDTH-1:0]             sdram_addr;
  logic                              sdram_write;
  logic                              sdram_burst;
  logic [BW-1:0]                     sdram_byte_enable;
  logic [DATA_WIDTH-1:0]             sdram_wdata;
  logic                              sdram_ack;
  logic [DATA_WIDTH-1:0]             sdram_rdata;
  logic [ID_WIDTH-1:0]               sdram_rdvalid;
  logic                              sdram_complete;
  logic                              err_bad_id;

  modport slave (
    input  bus_request,
    input  bus_lock,
    input  bus_addr,
    input  bus_write,
    input  bus_burst,
    input  bus_byte_enable,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata,
    output bus_rdvalid,
    output bus_complete,
    output sdram_req,
    output sdram_addr,
    output sdram_write,
    output sdram_burst,
    output sdram_byte_enable,
    output sdram_wdata,
    input  sdram_ack,
    input  sdram_rdata,
    input  sdram_rdvalid,
    input  sdram_complete,
    output err_bad_id
  );

  modport master (
    output bus_request,
    output bus_lock,
    output bus_addr,
    output bus_write,
    output bus_burst,
    output bus_byte_enable,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata,
    input  bus_rdvalid,
    input  bus_complete,
    input  sdram_req,
    input  sdram_addr,
    input  sdram_write,
    input  sdram_burst,
    input  sdram_byte_enable,
    input  sdram_wdata,
    output sdram_ack,
    output sdram_rdata,
    output sdram_rdvalid,
    output sdram_complete,
    input  err_bad_id
  );

endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: lowest-index or rotating priority pick over N requests.
// The request vector is doubled so the wrap-around search is one masked scan.
module rr_priority_picker
  import sdram_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  arb_mode_t     mode,
  output logic          grant_valid,
  output logic [IW-1:0] grant_index
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] hit;

  assign dbl = {req, req};
  assign hit = dbl & mask;

  // Search window: ptr+1 .. ptr+N in rotating mode, 0 .. N-1 otherwise.
  always_comb begin
    mask = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (mode == ARB_RR)
        mask[i] = (i > int'(ptr)) && (i <= int'(ptr) + N);
      else
        mask[i] = (i < N);
    end
  end

  // Lowest hit in the window wins, folded back to a master index.
  always_comb begin
    grant_valid = |hit;
    grant_index = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (hit[i])
        grant_index = IW'(i % N);
    end
  end

endmodule

// File: rtl/sdram_arbiter_rr.sv
// sdram_arbiter_rr: N-master front end for the SDRAM controller with
// selectable policy, bounded bus lock and ID-routed read returns.
module sdram_arbiter_rr
  import sdram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 3,
  parameter int ARB_MODE    = 1,
  parameter int LOCK_LIMIT  = 8
) (
  input logic               clock,
  input logic               reset_n,
  sdram_arbiter_rr_if.slave bus
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(LOCK_LIMIT + 1);
  localparam int BW = DATA_WIDTH / 8;
  localparam arb_mode_t MODE = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;
  localparam logic [ID_WIDTH-1:0] NO_ID = ID_WIDTH'(ID_NONE);

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       own_q, own_d;
  logic [IW-1:0]       last_q, last_d;
  logic [ID_WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q;

  logic                hold_vld;
  logic [IW-1:0]       hold_idx;
  logic                hold_req;
  logic                lock_win;
  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  logic                sel_vld;
  logic [IW-1:0]       sel_idx;
  logic                cur_vld;
  logic [IW-1:0]       cur_idx;
  logic [ID_WIDTH-1:0] cur_id;
  logic                take;
  logic [NUM_MASTERS-1:0] rv;
  logic                bad_id;

  rr_priority_picker #(
    .N (NUM_MASTERS)
  ) u_pick (
    .req         (bus.bus_request),
    .ptr         (last_q),
    .mode        (MODE),
    .grant_valid (pick_vld),
    .grant_index (pick_idx)
  );

  // Lock override ahead of the policy pick; current master selection.
  always_comb begin
    hold_vld = (hold_q != NO_ID);
    hold_idx = IW'(id_to_index(int'(hold_q)));
    hold_req = hold_vld && bus.bus_request[hold_idx];
    lock_win = hold_req && (int'(cnt_q) < LOCK_LIMIT);
    sel_vld  = lock_win || pick_vld;
    sel_idx  = lock_win ? hold_idx : pick_idx;
    cur_vld  = reset_n && ((state_q == ST_OWNED) || sel_vld);
    cur_idx  = (state_q == ST_OWNED) ? own_q : sel_idx;
    cur_id   = ID_WIDTH'(int'(cur_idx) + 1);
    take     = cur_vld && bus.sdram_ack;
  end

  // Next ownership, pointer and lock bookkeeping.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE && hold_vld && !hold_req) begin
      hold_d = NO_ID;
      cnt_d  = '0;
    end
    if (take) begin
      state_d = ST_IDLE;
      last_d  = cur_idx;
      if (bus.bus_lock[cur_idx]) begin
        if (hold_d == cur_id) begin
          if (int'(cnt_q) < LOCK_LIMIT)
            cnt_d = cnt_q + CW'(1);
        end else begin
          hold_d = cur_id;
          cnt_d  = CW'(1);
        end
      end else if (hold_d != NO_ID && hold_d != cur_id) begin
        cnt_d = '0;
      end else begin
        hold_d = NO_ID;
        cnt_d  = '0;
      end
    end else if (state_q == ST_IDLE && sel_vld) begin
      state_d = ST_OWNED;
      own_d   = sel_idx;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      hold_q  <= NO_ID;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request mux toward the controller; zeros when nobody is selected.
  always_comb begin
    bus.bus_ack           = '0;
    bus.sdram_req         = NO_ID;
    bus.sdram_addr        = '0;
    bus.sdram_write       = 1'b0;
    bus.sdram_burst       = 1'b0;
    bus.sdram_byte_enable = '0;
    bus.sdram_wdata       = '0;
    if (cur_vld) begin
      bus.sdram_req   = cur_id;
      bus.sdram_addr  =
        bus.bus_addr[int'(cur_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.sdram_write = bus.bus_write[cur_idx];
      bus.sdram_burst = bus.bus_burst[cur_idx];
      bus.sdram_byte_enable =
        bus.bus_byte_enable[int'(cur_idx)*BW +: BW];
      bus.sdram_wdata =
        bus.bus_wdata[int'(cur_idx)*DATA_WIDTH +: DATA_WIDTH];
      bus.bus_ack[cur_idx] = bus.sdram_ack;
    end
  end

  // Return path: decode the controller's target ID.
  always_comb begin
    for (int k = 0; k < NUM_MASTERS; k++)
      rv[k] = reset_n &&
              (bus.sdram_rdvalid == ID_WIDTH'(k + 1));
    bad_id           = int'(bus.sdram_rdvalid) > NUM_MASTERS;
    bus.bus_rdvalid  = rv;
    bus.bus_complete = {NUM_MASTERS{bus.sdram_complete}} & rv;
    bus.bus_rdata    = (|rv) ? bus.sdram_rdata : '0;
    bus.err_bad_id   = err_q;
  end

  // Sticky out-of-range ID flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (bad_id)
      err_q <= 1'b1;
  end

endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// tb_sdram_arbiter_rr: directed scenarios plus randomized traffic on a
// round-robin and a fixed-priority instance against a behavioural model.
module tb_sdram_arbiter_rr;

  localparam int N   = 4;
  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int IDW = 3;
  localparam int BW  = DW / 8;
  localparam int LIM = 3;
  localparam int AWT = N * AW;
  localparam int BWT = N * BW;
  localparam int DWT = N * DW;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]   req [2];
  logic [N-1:0]   lck [2];
  logic [N-1:0]   wr  [2];
  logic [N-1:0]   bst [2];
  logic [AWT-1:0] adr [2];
  logic [BWT-1:0] be  [2];
  logic [DWT-1:0] wd  [2];
  logic           sack [2];
  logic [DW-1:0]  srd [2];
  logic [IDW-1:0] srv [2];
  logic           scmp [2];

  logic [N-1:0]   o_ack [2];
  logic [N-1:0]   o_rv  [2];
  logic [N-1:0]   o_cmp [2];
  logic [DW-1:0]  o_rd  [2];
  logic [IDW-1:0] o_req [2];
  logic [31:0]    o_fld [2];
  logic [DW-1:0]  o_wd  [2];
  logic           o_err [2];

  sdram_arbiter_rr_if #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .ID_WIDTH(IDW)
  ) if_rr ();
  sdram_arbiter_rr_if #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .ID_WIDTH(IDW)
  ) if_fp ();

  sdram_arbiter_rr #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_WIDTH(IDW), .ARB_MODE(1), .LOCK_LIMIT(LIM)
  ) dut_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_rr)
  );

  sdram_arbiter_rr #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_WIDTH(IDW), .ARB_MODE(0), .LOCK_LIMIT(LIM)
  ) dut_fp (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_fp)
  );

  assign if_rr.bus_request     = req[0];
  assign if_rr.bus_lock        = lck[0];
  assign if_rr.bus_addr        = adr[0];
  assign if_rr.bus_write       = wr[0];
  assign if_rr.bus_burst       = bst[0];
  assign if_rr.bus_byte_enable = be[0];
  assign if_rr.bus_wdata       = wd[0];
  assign if_rr.sdram_ack       = sack[0];
  assign if_rr.sdram_rdata     = srd[0];
  assign if_rr.sdram_rdvalid   = srv[0];
  assign if_rr.sdram_complete  = scmp[0];

  assign if_fp.bus_request     = req[1];
  assign if_fp.bus_lock        = lck[1];
  assign if_fp.bus_addr        = adr[1];
  assign if_fp.bus_write       = wr[1];
  assign if_fp.bus_burst       = bst[1];
  assign if_fp.bus_byte_enable = be[1];
  assign if_fp.bus_wdata       = wd[1];
  assign if_fp.sdram_ack       = sack[1];
  assign if_fp.sdram_rdata     = srd[1];
  assign if_fp.sdram_rdvalid   = srv[1];
  assign if_fp.sdram_complete  = scmp[1];

  assign o_ack[0] = if_rr.bus_ack;
  assign o_rv[0]  = if_rr.bus_rdvalid;
  assign o_cmp[0] = if_rr.bus_complete;
  assign o_rd[0]  = if_rr.bus_rdata;
  assign o_req[0] = if_rr.sdram_req;
  assign o_wd[0]  = if_rr.sdram_wdata;
  assign o_err[0] = if_rr.err_bad_id;
  assign o_fld[0] = {if_rr.sdram_write, if_rr.sdram_burst,
                     if_rr.sdram_byte_enable, if_rr.sdram_addr};

  assign o_ack[1] = if_fp.bus_ack;
  assign o_rv[1]  = if_fp.bus_rdvalid;
  assign o_cmp[1] = if_fp.bus_complete;
  assign o_rd[1]  = if_fp.bus_rdata;
  assign o_req[1] = if_fp.sdram_req;
  assign o_wd[1]  = if_fp.sdram_wdata;
  assign o_err[1] = if_fp.err_bad_id;
  assign o_fld[1] = {if_fp.sdram_write, if_fp.sdram_burst,
                     if_fp.sdram_byte_enable, if_fp.sdram_addr};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model state: owner ID, last granted index, lock holder ID, count.
  int m_own [2];
  int m_last [2];
  int m_hold [2];
  int m_cnt [2];
  int m_err [2];
  logic [N-1:0] mack [2];

  int lseq [7] = '{1, 2, 3, 3, 3, 4, 3};

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; lck[d] = '0; wr[d] = '0; bst[d] = '0;
      adr[d] = '0; be[d] = '0; wd[d] = '0; sack[d] = 1'b0;
      srd[d] = '0; srv[d] = '0; scmp[d] = 1'b0;
      mack[d] = '0;
      m_own[d] = 0; m_last[d] = N - 1; m_hold[d] = 0;
      m_cnt[d] = 0; m_err[d] = 0;
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    nxt();
    reset_n = 1'b1;
  endtask

  // Who the spec says gets the bus when nobody owns it.
  function automatic int pick(input int d);
    int idx;
    if (m_hold[d] != 0 && req[d][m_hold[d]-1] && m_cnt[d] < LIM)
      return m_hold[d];
    for (int s = 1; s <= N; s++) begin
      idx = (d == 0) ? (m_last[d] + s) % N : s - 1;
      if (req[d][idx])
        return idx + 1;
    end
    return 0;
  endfunction

  task automatic model_cycle(input int d);
    int cur;
    string p;
    logic [N-1:0] eack;
    logic [N-1:0] erv;
    logic [31:0] efld;
    logic [DW-1:0] ewd;
    p = (d == 0) ? "rr_" : "fp_";
    cur = (m_own[d] != 0) ? m_own[d] : pick(d);
    eack = '0;
    efld = '0;
    ewd = '0;
    if (cur != 0) begin
      eack[cur-1] = sack[d];
      efld = {wr[d][cur-1], bst[d][cur-1],
              be[d][(cur-1)*BW +: BW], adr[d][(cur-1)*AW +: AW]};
      ewd = wd[d][(cur-1)*DW +: DW];
    end
    for (int k = 0; k < N; k++)
      erv[k] = (int'(srv[d]) == k + 1);
    chk({p, "req"}, o_req[d], cur);
    chk({p, "ack"}, o_ack[d], eack);
    chk({p, "fields"}, o_fld[d], efld);
    chk({p, "wdata"}, o_wd[d], ewd);
    chk({p, "rdvalid"}, o_rv[d], erv);
    chk({p, "complete"}, o_cmp[d], erv & {N{scmp[d]}});
    chk({p, "rdata"}, o_rd[d], (erv != 0) ? srd[d] : '0);
    chk({p, "err"}, o_err[d], m_err[d]);
    mack[d] = eack;
    if (int'(srv[d]) > N)
      m_err[d] = 1;
    if (m_own[d] == 0 && m_hold[d] != 0 && !req[d][m_hold[d]-1]) begin
      m_hold[d] = 0;
      m_cnt[d] = 0;
    end
    if (cur != 0 && sack[d]) begin
      m_own[d] = 0;
      m_last[d] = cur - 1;
      if (lck[d][cur-1]) begin
        if (m_hold[d] == cur) begin
          m_cnt[d] = (m_cnt[d] < LIM) ? m_cnt[d] + 1 : LIM;
        end else begin
          m_hold[d] = cur;
          m_cnt[d] = 1;
        end
      end else if (m_hold[d] != 0 && m_hold[d] != cur) begin
        m_cnt[d] = 0;
      end else begin
        m_hold[d] = 0;
        m_cnt[d] = 0;
      end
    end else if (m_own[d] == 0) begin
      m_own[d] = cur;
    end
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    nxt();
    #3;
    chk("reset_req", o_req[0], 0);
    chk("reset_ack", o_ack[0], 0);
    chk("reset_err", o_err[0], 0);
    nxt();
    reset_n = 1'b1;

    // Same-cycle grant and ack from idle.
    req[0] = 4'b1000;
    sack[0] = 1'b1;
    #3;
    chk("same_req", o_req[0], 4);
    chk("same_ack", o_ack[0], 4'b1000);
    nxt();
    req[0] = '0;
    sack[0] = 1'b0;
    #3;
    chk("same_idle", o_req[0], 0);

    // Bounded lock on master 2 with everyone requesting.
    do_reset();
    req[0] = 4'b1111;
    lck[0] = 4'b0100;
    sack[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #3;
      chk($sformatf("lock_req%0d", i), o_req[0], lseq[i]);
      chk($sformatf("lock_ack%0d", i), o_ack[0],
          64'd1 << (lseq[i] - 1));
      nxt();
    end

    // Round-robin fairness with an ack every second cycle.
    do_reset();
    req[0] = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      sack[0] = 1'b0;
      #3;
      chk($sformatf("rr_own%0d", i), o_req[0], (i % N) + 1);
      chk($sformatf("rr_noack%0d", i), o_ack[0], 0);
      nxt();
      sack[0] = 1'b1;
      #3;
      chk($sformatf("rr_req%0d", i), o_req[0], (i % N) + 1);
      chk($sformatf("rr_ack%0d", i), o_ack[0],
          64'd1 << (i % N));
      nxt();
    end

    // Fixed priority: master 1 beats master 3 until it lets go.
    do_reset();
    req[1] = 4'b1010;
    sack[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("fp_low_req", o_req[1], 2);
      chk("fp_low_ack", o_ack[1], 4'b0010);
      nxt();
    end
    req[1] = 4'b1000;
    #3;
    chk("fp_hi_req", o_req[1], 4);
    chk("fp_hi_ack", o_ack[1], 4'b1000);
    nxt();

    // Reset while master 2 owns the bus.
    do_reset();
    req[0] = 4'b0100;
    #3;
    chk("own_grant", o_req[0], 3);
    nxt();
    req[0] = 4'b0101;
    #3;
    chk("own_hold", o_req[0], 3);
    sack[0] = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rst_req", o_req[0], 0);
    chk("rst_ack", o_ack[0], 0);
    nxt();
    reset_n = 1'b1;
    req[0] = 4'b0001;
    sack[0] = 1'b0;
    #3;
    chk("rst_regrant", o_req[0], 1);
    nxt();

    // Return routing and the sticky bad-ID flag.
    do_reset();
    srv[0] = 3'd2;
    scmp[0] = 1'b1;
    srd[0] = 32'hDEADBEEF;
    #3;
    chk("ret_rv", o_rv[0], 4'b0010);
    chk("ret_cmp", o_cmp[0], 4'b0010);
    chk("ret_rd", o_rd[0], 32'hDEADBEEF);
    chk("ret_err0", o_err[0], 0);
    nxt();
    srv[0] = 3'd6;
    #3;
    chk("bad_rv", o_rv[0], 0);
    chk("bad_rd", o_rd[0], 0);
    nxt();
    srv[0] = '0;
    scmp[0] = 1'b0;
    #3;
    chk("bad_err1", o_err[0], 1);
    nxt();
    #3;
    chk("bad_err2", o_err[0], 1);

    // Randomized traffic on both instances against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < N; k++) begin
          if (req[d][k] && mack[d][k])
            req[d][k] = 1'b0;
          else if (!req[d][k])
            req[d][k] = ($urandom_range(0, 2) == 0);
        end
        lck[d]  = N'($urandom);
        wr[d]   = N'($urandom);
        bst[d]  = N'($urandom);
        adr[d]  = AWT'({$urandom, $urandom, $urandom, $urandom});
        be[d]   = BWT'($urandom);
        wd[d]   = DWT'({$urandom, $urandom, $urandom, $urandom});
        sack[d] = $urandom_range(0, 1) == 1;
        srd[d]  = $urandom;
        scmp[d] = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 15) == 0)
          srv[d] = IDW'($urandom_range(0, 7));
        else
          srv[d] = IDW'($urandom_range(0, N));
      end
      #3;
      model_cycle(0);
      model_cycle(1);
      nxt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
